alarm_bank: RTL and testbench

- Multi-channel alarm block; successor to the single-alarm unit. Holds NUM_ALARMS independently armed HH:MM alarms, each programmed digit-by-digit from the one-hot keypad with range validation.
- A shared ring engine handles triggering, snooze, stop and auto-timeout. The block sits beside the clock/time-keeping block and the LED driver, on the 1 kHz system clock.

---
 rtl/alarm_bank_if.sv | 41 ++++
 rtl/alarm_bank.sv | 228 ++++++++++++++++++++++
 tb/tb_alarm_bank.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Keypad, time, control and status bundle between the alarm bank and its host.
// master drives keys/buttons/current time; slave is the alarm bank itself.
interface alarm_bank_if #(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = 2
);
    logic [9:0]               keypad;
    logic                     set_mode;
    logic [SEL_W-1:0]         alarm_sel;
    logic                     clear_key;
    logic                     snooze_btn;
    logic                     stop_btn;
    logic [3:0]               cur_h_ten;
    logic [3:0]               cur_h_one;
    logic [3:0]               cur_m_ten;
    logic [3:0]               cur_m_one;
    logic                     min_tick;
    logic [16*NUM_ALARMS-1:0] alarm_time;
    logic [NUM_ALARMS-1:0]    alarm_armed;
    logic [2:0]               entry_cnt;
    logic                     set_done;
    logic                     entry_err;
    logic                     ringing;
    logic                     snoozed;
    logic [SEL_W-1:0]         ring_id;
    logic [7:0]               leds;

    modport master (
        output keypad, set_mode, alarm_sel, clear_key, snooze_btn, stop_btn,
               cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, min_tick,
        input  alarm_time, alarm_armed, entry_cnt, set_done, entry_err,
               ringing, snoozed, ring_id, leds
    );

    modport slave (
        input  keypad, set_mode, alarm_sel, clear_key, snooze_btn, stop_btn,
               cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, min_tick,
        output alarm_time, alarm_armed, entry_cnt, set_done, entry_err,
               ringing, snoozed, ring_id, leds
    );
endinterface

// File: rtl/alarm_bank.sv
// Multi-slot HH:MM alarm bank: keypad entry with range checks plus a shared
// ring engine (pending queue, snooze, stop, unattended timeout, LED blink).
//
// state      | meaning
// E_IDLE     | no entry in progress
// E_D1..E_D3 | 1..3 validated digits held in the shadow register
// R_IDLE     | nothing sounding; lowest pending slot is taken next cycle
// R_RINGING  | slot ring_id sounding, LEDs blinking
// R_SNOOZED  | snooze countdown running before re-ringing ring_id
module alarm_bank #(
    parameter int NUM_ALARMS   = 4,
    parameter int SEL_W        = 2,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MIN     = 1,
    parameter int BLINK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    alarm_bank_if.slave bus
);
    typedef enum logic [1:0] {E_IDLE, E_D1, E_D2, E_D3} e_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RINGING, R_SNOOZED} r_state_t;

    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    e_state_t                   e_state_q, e_state_d;
    r_state_t                   r_state_q, r_state_d;
    logic [SEL_W-1:0]           sel_q, sel_d, ring_id_q, ring_id_d, first_idx;
    logic [11:0]                shadow_q, shadow_d;
    logic [NUM_ALARMS-1:0][15:0] alarm_time_q, alarm_time_d;
    logic [NUM_ALARMS-1:0]      armed_q, armed_d, match, match_q, pending_q, pending_d;
    logic                       set_done_q, set_done_d, entry_err_q, entry_err_d;
    logic [9:0]                 keypad_prev_q;
    logic                       snooze_prev_q, stop_prev_q;
    logic [3:0]                 min_left_q, min_left_d;
    logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
    logic                       blink_on_q, blink_on_d;
    logic                       key_evt, digit_ok, commit, disarm, hit_ring, enter_ring;
    logic                       snooze_edge, stop_edge, sel_ok, slot_ok;
    logic [3:0]                 digit;
    logic [15:0]                cur_time;

    assign cur_time    = {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten, bus.cur_m_one};
    assign key_evt     = $onehot(bus.keypad) && (keypad_prev_q == '0);
    assign snooze_edge = bus.snooze_btn && !snooze_prev_q;
    assign stop_edge   = bus.stop_btn && !stop_prev_q;
    assign sel_ok      = int'(bus.alarm_sel) < NUM_ALARMS;
    assign slot_ok     = int'(sel_q) < NUM_ALARMS;

    always_comb begin
        digit = '0;
        for (int k = 0; k < 10; k++) if (bus.keypad[k]) digit = 4'(k);
    end

    always_comb begin
        case (e_state_q)
            E_IDLE:  digit_ok = (digit <= 4'd2);
            E_D1:    digit_ok = (shadow_q[11:8] == 4'd2) ? (digit <= 4'd3) : (digit <= 4'd9);
            E_D2:    digit_ok = (digit <= 4'd5);
            default: digit_ok = (digit <= 4'd9);
        endcase
    end

    always_comb begin
        e_state_d    = e_state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        alarm_time_d = alarm_time_q;
        armed_d      = armed_q;
        entry_err_d  = 1'b0;
        commit       = 1'b0;
        disarm       = 1'b0;
        if (e_state_q != E_IDLE && (!bus.set_mode || bus.clear_key)) begin
            e_state_d = E_IDLE;
            shadow_d  = '0;
        end else if (e_state_q == E_IDLE && bus.set_mode && bus.clear_key) begin
            disarm = 1'b1;
            if (sel_ok) armed_d[bus.alarm_sel] = 1'b0;
        end else if (bus.set_mode && key_evt) begin
            if (!digit_ok) begin
                entry_err_d = 1'b1;
            end else begin
                case (e_state_q)
                    E_IDLE: begin
                        sel_d     = bus.alarm_sel;
                        shadow_d  = {digit, 8'h00};
                        e_state_d = E_D1;
                    end
                    E_D1: begin
                        shadow_d[7:4] = digit;
                        e_state_d     = E_D2;
                    end
                    E_D2: begin
                        shadow_d[3:0] = digit;
                        e_state_d     = E_D3;
                    end
                    default: begin
                        commit = 1'b1;
                        if (slot_ok) begin
                            alarm_time_d[sel_q] = {shadow_q, digit};
                            armed_d[sel_q]      = 1'b1;
                        end
                        shadow_d  = '0;
                        e_state_d = E_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_ALARMS; k++)
            match[k] = armed_q[k] && (alarm_time_q[k] == cur_time);
        first_idx = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--)
            if (pending_q[k]) first_idx = SEL_W'(k);
    end

    assign hit_ring = (commit && sel_q == ring_id_q) || (disarm && bus.alarm_sel == ring_id_q);

    always_comb begin
        r_state_d  = r_state_q;
        ring_id_d  = ring_id_q;
        min_left_d = min_left_q;
        enter_ring = 1'b0;
        pending_d  = pending_q | (match & ~match_q);
        // Free-running half-period timer; reloaded on every entry to RINGING.
        if (blink_cnt_q == '0) begin
            blink_cnt_d = BLINK_LOAD;
            blink_on_d  = !blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
            blink_on_d  = blink_on_q;
        end
        case (r_state_q)
            R_IDLE: begin
                if (|pending_q) begin
                    enter_ring           = 1'b1;
                    ring_id_d            = first_idx;
                    pending_d[first_idx] = 1'b0;
                end
            end
            R_RINGING: begin
                if (hit_ring || stop_edge) begin
                    r_state_d = R_IDLE;
                end else if (snooze_edge) begin
                    r_state_d  = R_SNOOZED;
                    min_left_d = 4'(SNOOZE_MIN);
                end else if (bus.min_tick) begin
                    if (min_left_q <= 4'd1) r_state_d = R_IDLE;
                    else                    min_left_d = min_left_q - 4'd1;
                end
            end
            R_SNOOZED: begin
                if (hit_ring || stop_edge) begin
                    r_state_d = R_IDLE;
                end else if (bus.min_tick) begin
                    if (min_left_q <= 4'd1) enter_ring = 1'b1;
                    else                    min_left_d = min_left_q - 4'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (enter_ring) begin
            r_state_d   = R_RINGING;
            min_left_d  = 4'(RING_MIN);
            blink_cnt_d = BLINK_LOAD;
            blink_on_d  = 1'b1;
        end
        if (disarm && sel_ok) pending_d[bus.alarm_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_state_q     <= E_IDLE;
            r_state_q     <= R_IDLE;
            sel_q         <= '0;
            ring_id_q     <= '0;
            shadow_q      <= '0;
            alarm_time_q  <= '0;
            armed_q       <= '0;
            match_q       <= '0;
            pending_q     <= '0;
            set_done_q    <= 1'b0;
            entry_err_q   <= 1'b0;
            keypad_prev_q <= '0;
            snooze_prev_q <= 1'b0;
            stop_prev_q   <= 1'b0;
            min_left_q    <= '0;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b0;
        end else begin
            e_state_q     <= e_state_d;
            r_state_q     <= r_state_d;
            sel_q         <= sel_d;
            ring_id_q     <= ring_id_d;
            shadow_q      <= shadow_d;
            alarm_time_q  <= alarm_time_d;
            armed_q       <= armed_d;
            match_q       <= match;
            pending_q     <= pending_d;
            set_done_q    <= commit;
            entry_err_q   <= entry_err_d;
            keypad_prev_q <= bus.keypad;
            snooze_prev_q <= bus.snooze_btn;
            stop_prev_q   <= bus.stop_btn;
            min_left_q    <= min_left_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
        end
    end

    assign set_done_d      = commit;
    assign bus.alarm_time  = alarm_time_q;
    assign bus.alarm_armed = armed_q;
    assign bus.entry_cnt   = {1'b0, e_state_q};
    assign bus.set_done    = set_done_q;
    assign bus.entry_err   = entry_err_q;
    assign bus.ringing     = (r_state_q == R_RINGING);
    assign bus.snoozed     = (r_state_q == R_SNOOZED);
    assign bus.ring_id     = ring_id_q;
    assign bus.leds        = (r_state_q == R_RINGING) ? (blink_on_q ? 8'hFF : 8'h00) :
                             (r_state_q == R_SNOOZED) ? 8'h01 : 8'h00;

    logic unused_ok;
    assign unused_ok = set_done_d;
endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: an event-level reference model queues the
// expected commits, digit rejections and ring-engine transitions; a monitor pops them.
module tb_alarm_bank;
    localparam int NA = 4, SW = 2, SNZ = 5, RMIN = 1, BLINK = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_bank_if #(.NUM_ALARMS(NA), .SEL_W(SW)) bus ();

    alarm_bank #(.NUM_ALARMS(NA), .SEL_W(SW), .SNOOZE_MIN(SNZ), .RING_MIN(RMIN),
                 .BLINK_CYCLES(BLINK)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // kind: 0 commit, 1 rejected digit, 2 ring-engine state change (st 0 idle, 1 ringing, 2 snoozed)
    typedef struct {
        int          kind;
        int          slot;
        logic [15:0] tm;
        int          st;
        int          id;
        logic [7:0]  led;
        int          cnt;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    bit          mon_en = 1'b0;

    int          m_pos, m_sel, m_st, m_id, m_min;
    int          m_dig[4];
    logic [15:0] m_time[NA];
    bit          m_armed[NA], m_match[NA], m_pend[NA];
    logic [15:0] m_cur;
    bit          m_setmode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0; m_sel = 0; m_st = 0; m_id = 0; m_min = 0;
        for (int i = 0; i < NA; i++) begin
            m_time[i] = '0; m_armed[i] = 0; m_match[i] = 0; m_pend[i] = 0;
        end
    endfunction

    function automatic void push_ring();
        ev_t e;
        e.kind = 2; e.slot = 0; e.tm = '0; e.cnt = 0;
        e.st = m_st; e.id = m_id;
        e.led = (m_st == 1) ? 8'hFF : (m_st == 2) ? 8'h01 : 8'h00;
        exp_q.push_back(e);
    endfunction

    function automatic void model_update();
        for (int i = 0; i < NA; i++) begin
            bit nm;
            nm = m_armed[i] && (m_time[i] == m_cur);
            if (nm && !m_match[i]) m_pend[i] = 1;
            m_match[i] = nm;
        end
    endfunction

    function automatic void model_take();
        if (m_st != 0) return;
        for (int i = 0; i < NA; i++) begin
            if (m_pend[i]) begin
                m_pend[i] = 0; m_st = 1; m_id = i; m_min = 0;
                push_ring();
                return;
            end
        end
    endfunction

    function automatic void model_key(input int d, input int sel);
        bit  ok;
        ev_t e;
        if (!m_setmode) return;
        case (m_pos)
            0:       ok = (d * 10 <= 23);
            1:       ok = (m_dig[0] * 10 + d <= 23);
            2:       ok = (d <= 5);
            default: ok = 1;
        endcase
        if (!ok) begin
            e.kind = 1; e.slot = 0; e.tm = '0; e.st = 0; e.id = 0; e.led = '0; e.cnt = m_pos;
            exp_q.push_back(e);
            return;
        end
        if (m_pos == 0) m_sel = sel;
        m_dig[m_pos] = d;
        m_pos++;
        if (m_pos == 4) begin
            m_pos = 0;
            m_time[m_sel] = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
            m_armed[m_sel] = 1;
            e.kind = 0; e.slot = m_sel; e.tm = m_time[m_sel]; e.st = 0; e.id = 0; e.led = '0; e.cnt = 0;
            exp_q.push_back(e);
            if (m_st != 0 && m_id == m_sel) begin
                m_st = 0;
                push_ring();
            end
            model_update();
            model_take();
        end
    endfunction

    function automatic void model_clear(input int sel);
        if (!m_setmode) return;
        if (m_pos > 0) begin
            m_pos = 0;
            return;
        end
        m_armed[sel] = 0;
        m_pend[sel]  = 0;
        if (m_st != 0 && m_id == sel) begin
            m_st = 0;
            push_ring();
        end
        model_update();
        model_take();
    endfunction

    function automatic logic [NA-1:0] model_armed_vec();
        logic [NA-1:0] v;
        for (int i = 0; i < NA; i++) v[i] = m_armed[i];
        return v;
    endfunction

    function automatic logic [16*NA-1:0] model_time_vec();
        logic [16*NA-1:0] v;
        for (int i = 0; i < NA; i++) v[16*i +: 16] = m_time[i];
        return v;
    endfunction

    task automatic press(input int d, input int sel);
        model_key(d, sel);
        bus.alarm_sel = SW'(sel);
        bus.keypad    = 10'(1 << d);
        @(negedge clk);
        bus.keypad = '0;
        @(negedge clk);
    endtask

    task automatic clear(input int sel);
        model_clear(sel);
        bus.alarm_sel = SW'(sel);
        bus.clear_key = 1'b1;
        @(negedge clk);
        bus.clear_key = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_mode_to(input bit v);
        m_setmode = v;
        if (!v) m_pos = 0;
        bus.set_mode = v;
        @(negedge clk);
    endtask

    task automatic set_time(input logic [15:0] t);
        m_cur = t;
        {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten, bus.cur_m_one} = t;
        model_update();
        model_take();
        @(negedge clk);
    endtask

    task automatic buttons(input bit snz, input bit stp);
        if (stp) begin
            if (m_st != 0) begin
                m_st = 0;
                push_ring();
                model_take();
            end
        end else if (snz && m_st == 1) begin
            m_st = 2; m_min = 0;
            push_ring();
        end
        bus.snooze_btn = snz;
        bus.stop_btn   = stp;
        repeat (3) @(negedge clk);
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        if (m_st == 1) begin
            m_min++;
            if (m_min >= RMIN) begin
                m_st = 0;
                push_ring();
                model_take();
            end
        end else if (m_st == 2) begin
            m_min++;
            if (m_min >= SNZ) begin
                m_st = 1; m_min = 0;
                push_ring();
            end
        end
        bus.min_tick = 1'b1;
        @(negedge clk);
        bus.min_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alarm_time"}, bus.alarm_time, '0);
        check({tag, "_armed"}, bus.alarm_armed, '0);
        check({tag, "_entry_cnt"}, bus.entry_cnt, '0);
        check({tag, "_pulses"}, {bus.set_done, bus.entry_err}, '0);
        check({tag, "_ring_state"}, {bus.ringing, bus.snoozed}, '0);
        check({tag, "_ring_id"}, bus.ring_id, '0);
        check({tag, "_leds"}, bus.leds, '0);
    endtask

    // Monitor: pops one expectation per DUT output event.
    initial begin
        bit  [1:0] prev, obs;
        ev_t       e;
        int        st;
        wait (mon_en);
        prev = {bus.snoozed, bus.ringing};
        forever begin
            @(negedge clk);
            if (bus.set_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_set_done: got pulse expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_commit", 0, e.kind);
                    if (e.kind == 0) begin
                        check("commit_time", bus.alarm_time[16*e.slot +: 16], e.tm);
                        check("commit_armed", bus.alarm_armed[e.slot], 1);
                    end
                end
            end
            if (bus.entry_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_entry_err: got pulse expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_err", 1, e.kind);
                    if (e.kind == 1) check("err_entry_cnt", bus.entry_cnt, e.cnt);
                end
            end
            obs = {bus.snoozed, bus.ringing};
            if (obs !== prev) begin
                st = bus.ringing ? 1 : bus.snoozed ? 2 : 0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ring_change: got state %0d expected none", st);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_ring", 2, e.kind);
                    if (e.kind == 2) begin
                        check("ring_state", {bus.snoozed, bus.ringing}, (e.st == 1) ? 2'b01 : (e.st == 2) ? 2'b10 : 2'b00);
                        check("ring_id", bus.ring_id, e.id);
                        check("ring_leds", bus.leds, e.led);
                    end
                end
            end
            prev = obs;
        end
    end

    initial begin
        int n;
        int marks[3] = '{499, 500, 1000};
        bus.keypad = '0; bus.set_mode = 1'b0; bus.alarm_sel = '0; bus.clear_key = 1'b0;
        bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0; bus.min_tick = 1'b0;
        {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten, bus.cur_m_one} = 16'hFFFF;
        m_cur = 16'hFFFF; m_setmode = 0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        set_mode_to(1);
        press(0, 2); press(7, 2); press(3, 2); press(0, 2);
        check("slot2_armed", bus.alarm_armed, model_armed_vec());
        check("entry_cnt_after_commit", bus.entry_cnt, 0);

        // alarm_sel moves mid-entry; the slot latched at the first digit must win
        press(2, 1); press(5, 0);
        check("entry_cnt_after_err", bus.entry_cnt, m_pos);
        press(3, 2); press(4, 3); press(5, 0);
        check("slot1_2345", bus.alarm_time[31:16], 16'h2345);
        press(3, 0);
        check("entry_cnt_first_err", bus.entry_cnt, 0);

        repeat (90) begin
            int r, s;
            r = $urandom_range(0, 11);
            s = $urandom_range(0, NA - 1);
            if (r >= 10) clear(s);
            else         press(r, s);
        end
        if (m_pos > 0) set_mode_to(0);
        set_mode_to(1);
        check("random_armed", bus.alarm_armed, model_armed_vec());
        check("random_times", bus.alarm_time, model_time_vec());

        press(1, 0); press(2, 0);
        check("entry_cnt_two", bus.entry_cnt, m_pos);
        set_mode_to(0);
        check("entry_cnt_abort", bus.entry_cnt, 0);
        check("abort_times", bus.alarm_time, model_time_vec());
        set_mode_to(1);
        for (int s = 0; s < NA; s++) clear(s);
        check("all_disarmed", bus.alarm_armed, 0);

        press(0, 0); press(8, 0); press(0, 0); press(0, 0);
        press(0, 1); press(8, 1); press(0, 1); press(0, 1);
        set_time(16'h0800);
        repeat (4) @(negedge clk);
        buttons(0, 1);
        repeat (3) @(negedge clk);
        buttons(1, 0);
        check("snooze_leds", bus.leds, 8'h01);
        repeat (SNZ) tick();
        repeat (2) @(negedge clk);
        buttons(1, 1);
        repeat (3) @(negedge clk);

        clear(1);
        set_time(16'h0801);
        set_time(16'h0800);
        @(negedge clk);
        n = 0;
        check("blink_n0", bus.leds, 8'hFF);
        foreach (marks[j]) begin
            while (n < marks[j]) begin
                @(negedge clk);
                n++;
            end
            check("blink_phase", bus.leds, ((n / BLINK) % 2 == 0) ? 8'hFF : 8'h00);
        end
        tick();
        repeat (3) @(negedge clk);

        set_time(16'h0801);
        set_time(16'h0800);
        repeat (4) @(negedge clk);
        clear(0);
        repeat (3) @(negedge clk);

        press(0, 3); press(9, 3); press(1, 3); press(5, 3);
        set_time(16'h0915);
        repeat (4) @(negedge clk);
        check("ringing_before_reset", bus.ringing, 1);
        model_reset();
        push_ring();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midring_reset");
        rst = 1'b0;
        {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten, bus.cur_m_one} = 16'hFFFF;
        m_cur = 16'hFFFF;
        repeat (3) @(negedge clk);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
